dpram_be: RTL and testbench
===========================

# dpram_be

Parametrised successor to the core's unified dual-port RAM. It serves the load/store unit through a data port and the fetch stage through an instruction port. Over the combinational-word-only design it adds registered (synchronous) reads, byte/half/word stores with sign/zero-extended loads, misalignment detection, and a configurable output pipeline stage. Byte order stays big-endian: the lowest byte address holds bits [31:24] of a word.

## Interface
- `ADDR_WIDTH`, 32: width of the incoming byte addresses (`d_addr_i`, `i_pc_i`).
- `RAM_ADDR_WIDTH`, 12: bytes of storage = 2**RAM_ADDR_WIDTH. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- `OUT_REG`, 0: 1 adds an output register stage on both ports. Read latency = 1 + OUT_REG.
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `d_req_i` in 1: data access request this cycle.
- `d_we_i` in 1: 1 = store, 0 = load.
- `d_size_i` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `d_unsigned_i` in 1: load zero-extends when 1, sign-extends when 0.
- `d_addr_i` in ADDR_WIDTH: byte address.
- `d_wdata_i` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `d_rvalid_o` out 1: response valid, pulses once per accepted request (loads and stores).
- `d_rdata_o` out 32: extended load data. 0 for stores and errors.
- `d_err_o` out 1: misaligned or reserved-size access. Qualified by `d_rvalid_o`.
- `i_req_i` in 1: fetch request.
- `i_pc_i` in ADDR_WIDTH: fetch byte address.
- `i_valid_o` out 1: fetch response valid.
- `i_inst_o` out 32: instruction word. 0 on error.
- `i_err_o` out 1: `i_pc_i[1:0] != 0`. Qualified by `i_valid_o`.

## Operation
- No backpressure: both ports accept a request every cycle, and responses return in order.
- Alignment:
  - Half requires `addr[0] == 0`.
  - Word requires `addr[1:0] == 0`.
  - `d_size_i == 11` is always an error.
  - An erroring store writes nothing; it still returns a response with `d_err_o` = 1.
- Store byte lanes, with A = the address masked to RAM_ADDR_WIDTH bits:
  - Byte: `mem[A]` <= wdata[7:0].
  - Half: `mem[A]` <= wdata[15:8], `mem[A+1]` <= wdata[7:0].
  - Word: `mem[A..A+3]` <= wdata[31:24], [23:16], [15:8], [7:0].
  - Untouched bytes are preserved.
- Load:
  - The full aligned word is read in the request cycle.
  - The byte or half is selected using the registered low address bits and size.
  - Result is extended to 32 bits per the registered `d_unsigned_i`.
  - Word loads ignore `d_unsigned_i`.
- Fetch: the instruction port reads the word at `{i_pc_i[RAM_ADDR_WIDTH-1:2], 2'b00}` as big-endian bytes.
- Collision: a data store and a fetch of the same word in the same cycle → the fetch returns the OLD word (read-before-write). A data load of the same address on the following cycle returns the new data.
- Memory contents are not cleared by reset; simulation preload is done externally.

## Timing
- `OUT_REG` = 0: request in cycle N → `*_valid_o`, data and err valid in cycle N+1.
- `OUT_REG` = 1: the same response appears in cycle N+2.
- A store commits at the edge closing cycle N. A load issued in N+1 sees it.
- Valids are single-cycle pulses. With no request in cycle N, `*_valid_o` = 0 in N+1 (N+2 with `OUT_REG`), and data/err outputs are driven 0.
- Reset values: `d_rvalid_o`, `d_rdata_o`, `d_err_o`, `i_valid_o`, `i_inst_o`, `i_err_o` are all 0.
- Reset asserted while requests are in flight: every pipeline stage is cleared, in-flight responses are dropped, and no response is emitted for them.
- A store presented in a cycle with `rst_i` = 1 does not write.
- Back-to-back requests with `OUT_REG` = 1 give full throughput: one response per cycle.

## Test plan
- **Word round trip.** `OUT_REG` = 0: store word 0x11223344 at 0x100, then load word at 0x100 → next cycle `d_rvalid_o` = 1, `d_rdata_o` = 0x11223344. A fetch at 0x100 returns `i_inst_o` = 0x11223344.
- **Sub-word store and loads.** Over word 0x11223344 at 0x100:
  - Store byte 0xAB at 0x102 → word reads 0x1122AB44.
  - lb at 0x102 → 0xFFFFFFAB.
  - lbu at 0x102 → 0x000000AB.
  - Store half 0x8001 at 0x100, then lh at 0x100 → 0xFFFF8001.
- **Misalignment.**
  - Store word at 0x101 → `d_err_o` = 1, `d_rdata_o` = 0, and 0x100 is unchanged.
  - Half at 0x103 → err.
  - `d_size_i` = 11 → err.
  - Fetch at 0x102 → `i_err_o` = 1, `i_inst_o` = 0.
- **Collision.** Word 0x200 holds 0xDEADBEEF. In the same cycle, store 0xCAFEF00D to 0x200 and fetch 0x200 → `i_inst_o` = 0xDEADBEEF. A fetch on the next cycle → 0xCAFEF00D.
- **Pipeline and reset.**
  - `OUT_REG` = 1: loads on 4 consecutive cycles → 4 consecutive valid responses, starting 2 cycles after the first request, in order.
  - Assert `rst_i` 1 cycle after 2 requests → no valids appear and all outputs are 0.
- **Wrap-around.** `RAM_ADDR_WIDTH` = 12: store at 0x0000_1004, then load at 0x0000_0004 → same data.

Source files
------------

// File: rtl/dpram_be.sv
// dpram_be: big-endian dual-port RAM with byte/half/word stores, extended loads and misalignment detection.
module dpram_be #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter bit OUT_REG = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [1:0]            d_size_i,
  input  logic                  d_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]           d_wdata_i,
  output logic                  d_rvalid_o,
  output logic [31:0]           d_rdata_o,
  output logic                  d_err_o,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_pc_i,
  output logic                  i_valid_o,
  output logic [31:0]           i_inst_o,
  output logic                  i_err_o
);
  localparam int WA = RAM_ADDR_WIDTH - 2;
  logic [31:0] mem [2**WA];
  logic [WA-1:0] d_idx, i_idx;
  logic [1:0] d_off, d_off_d, d_off_q, d_size_d, d_size_q;
  logic d_mis, d_wr;
  logic [3:0] d_be;
  logic [31:0] d_lane, d_word_d, d_word_q, i_word_d, i_word_q;
  logic d_v_d, d_v_q, d_err_d, d_err_q, d_ld_d, d_ld_q, d_uns_d, d_uns_q;
  logic i_v_d, i_v_q, i_err_d, i_err_q;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [31:0] d_rdata_c, i_inst_c;
  logic [67:0] out_d;
  logic unused_hi;
  assign unused_hi = ^{d_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH], i_pc_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH]};
  always_comb begin
    d_idx = d_addr_i[RAM_ADDR_WIDTH-1:2];
    i_idx = i_pc_i[RAM_ADDR_WIDTH-1:2];
    d_off = d_addr_i[1:0];
    d_mis = (d_size_i == 2'b11) | (d_size_i == 2'b01 & d_off[0]) | (d_size_i == 2'b10 & |d_off);
    d_wr = d_req_i & d_we_i & ~d_mis & ~rst_i;
    // lane 3 is the lowest byte address (big-endian)
    d_be = d_size_i == 2'b00 ? 4'b1000 >> d_off : d_size_i == 2'b01 ? (d_off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    d_lane = d_size_i == 2'b00 ? {4{d_wdata_i[7:0]}} : d_size_i == 2'b01 ? {2{d_wdata_i[15:0]}} : d_wdata_i;
    d_word_d = mem[d_idx];
    i_word_d = mem[i_idx];
    d_v_d = d_req_i;
    d_err_d = d_req_i & d_mis;
    d_ld_d = d_req_i & ~d_we_i & ~d_mis;
    d_off_d = d_off;
    d_size_d = d_size_i;
    d_uns_d = d_unsigned_i;
    i_v_d = i_req_i;
    i_err_d = i_req_i & |i_pc_i[1:0];
    ld_b = 8'(d_word_q >> {~d_off_q, 3'b000});
    ld_h = d_off_q[1] ? d_word_q[15:0] : d_word_q[31:16];
    d_rdata_c = ~d_ld_q ? 32'h0 :
                d_size_q == 2'b00 ? {{24{ld_b[7] & ~d_uns_q}}, ld_b} :
                d_size_q == 2'b01 ? {{16{ld_h[15] & ~d_uns_q}}, ld_h} : d_word_q;
    i_inst_c = i_v_q & ~i_err_q ? i_word_q : 32'h0;
    out_d = {d_v_q, d_err_q, d_rdata_c, i_v_q, i_err_q, i_inst_c};
  end
  // nonblocking read of the pre-write word gives read-before-write on the fetch port
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++)
      if (d_wr && d_be[b]) mem[d_idx][8*b +: 8] <= d_lane[8*b +: 8];
    d_word_q <= d_word_d;
    i_word_q <= i_word_d;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_v_q <= 1'b0;
      d_err_q <= 1'b0;
      d_ld_q <= 1'b0;
      d_off_q <= 2'b00;
      d_size_q <= 2'b00;
      d_uns_q <= 1'b0;
      i_v_q <= 1'b0;
      i_err_q <= 1'b0;
    end else begin
      d_v_q <= d_v_d;
      d_err_q <= d_err_d;
      d_ld_q <= d_ld_d;
      d_off_q <= d_off_d;
      d_size_q <= d_size_d;
      d_uns_q <= d_uns_d;
      i_v_q <= i_v_d;
      i_err_q <= i_err_d;
    end
  end
  generate
    if (OUT_REG) begin : g_out
      logic [67:0] out_q;
      always_ff @(posedge clk_i) out_q <= rst_i ? '0 : out_d;
      assign {d_rvalid_o, d_err_o, d_rdata_o, i_valid_o, i_err_o, i_inst_o} = out_q;
    end else begin : g_comb
      assign {d_rvalid_o, d_err_o, d_rdata_o, i_valid_o, i_err_o, i_inst_o} = out_d;
    end
  endgenerate
endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: runs both output-stage variants side by side against a byte-array reference model.
module tb_dpram_be;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, d_req = 1'b0, d_we = 1'b0, d_uns = 1'b0, i_req = 1'b0;
  logic [1:0] d_size = 2'b00;
  logic [31:0] d_addr = '0, d_wdata = '0, i_pc = '0;
  logic v0, er0, iv0, ie0, v1, er1, iv1, ie1;
  logic [31:0] rd0, in0, rd1, in1;
  logic [67:0] o0, o1, e0 = '0, e1 = '0, p = '0;
  logic [7:0] m [4096];
  int nc = 0, nf = 0;
  assign o0 = {v0, er0, rd0, iv0, ie0, in0};
  assign o1 = {v1, er1, rd1, iv1, ie1, in1};

  dpram_be #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(12), .OUT_REG(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size),
    .d_unsigned_i(d_uns), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rvalid_o(v0),
    .d_rdata_o(rd0), .d_err_o(er0), .i_req_i(i_req), .i_pc_i(i_pc), .i_valid_o(iv0),
    .i_inst_o(in0), .i_err_o(ie0));
  dpram_be #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(12), .OUT_REG(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size),
    .d_unsigned_i(d_uns), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rvalid_o(v1),
    .d_rdata_o(rd1), .d_err_o(er1), .i_req_i(i_req), .i_pc_i(i_pc), .i_valid_o(iv1),
    .i_inst_o(in1), .i_err_o(ie1));

  function automatic logic [31:0] mword(input logic [11:0] a);
    return {m[a], m[a + 12'd1], m[a + 12'd2], m[a + 12'd3]};
  endfunction

  // applies one cycle of stimulus, updates the model, and leaves e0/e1 as the expected outputs of u0/u1
  task automatic drive(input logic r, dq, we, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, wd, input logic iq, input logic [31:0] pc);
    logic [33:0] ed, ei;
    logic err;
    logic [11:0] ad;
    logic [7:0] b;
    logic [15:0] h;
    rst = r; d_req = dq; d_we = we; d_size = sz; d_uns = un; d_addr = a; d_wdata = wd;
    i_req = iq; i_pc = pc;
    ad = a[11:0];
    err = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    b = m[ad];
    h = {m[ad], m[ad + 12'd1]};
    ed = '0;
    ei = '0;
    if (!r && dq) begin
      ed[33] = 1'b1;
      ed[32] = err;
      if (!err && !we)
        ed[31:0] = sz == 2'd0 ? (un ? {24'h0, b} : {{24{b[7]}}, b}) :
                   sz == 2'd1 ? (un ? {16'h0, h} : {{16{h[15]}}, h}) : mword(ad);
    end
    if (!r && iq) ei = {1'b1, pc[1:0] != 2'd0, pc[1:0] != 2'd0 ? 32'h0 : mword({pc[11:2], 2'b00})};
    if (!r && dq && we && !err) begin
      if (sz == 2'd0) m[ad] = wd[7:0];
      else if (sz == 2'd1) begin m[ad] = wd[15:8]; m[ad + 12'd1] = wd[7:0]; end
      else begin
        m[ad] = wd[31:24]; m[ad + 12'd1] = wd[23:16]; m[ad + 12'd2] = wd[15:8]; m[ad + 12'd3] = wd[7:0];
      end
    end
    @(posedge clk);
    #1;
    e0 = {ed, ei};
    e1 = r ? '0 : p;
    p = e0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 2, 0, 32'h100, 0, 1, 32'h100);
      nc++; if ({o0, o1} !== '0) begin nf++; $display("FAIL reset_state got %h exp 0", {o0, o1}); end
    end
    drive(0, 1, 1, 2, 0, 32'h104, 32'h0A0B0C0D, 0, 0);
    nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL rst_pre_store got %h exp %h", {o0, o1}, {e0, e1}); end
    drive(1, 1, 1, 2, 0, 32'h104, 32'hFFFFFFFF, 0, 0);
    nc++; if ({o0, o1} !== '0) begin nf++; $display("FAIL rst_store got %h exp 0", {o0, o1}); end
    drive(0, 1, 0, 2, 0, 32'h104, 0, 0, 0);
    nc++; if (rd0 !== 32'h0A0B0C0D) begin nf++; $display("FAIL rst_no_write got %h exp 0a0b0c0d", rd0); end
    nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL rst_load got %h exp %h", {o0, o1}, {e0, e1}); end
  endtask

  task automatic test_word_roundtrip;
    drive(0, 1, 1, 2, 0, 32'h100, 32'h11223344, 0, 0);
    nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL rt_store got %h exp %h", {o0, o1}, {e0, e1}); end
    drive(0, 1, 0, 2, 0, 32'h100, 0, 1, 32'h100);
    nc++; if ({v0, rd0, in0} !== {1'b1, 32'h11223344, 32'h11223344}) begin nf++; $display("FAIL rt_load got %h exp 1_11223344_11223344", {v0, rd0, in0}); end
    nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL rt_model got %h exp %h", {o0, o1}, {e0, e1}); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL rt_idle got %h exp %h", {o0, o1}, {e0, e1}); end
  endtask

  task automatic test_subword;
    logic [31:0] want [5] = '{32'h0, 32'h1122AB44, 32'hFFFFFFAB, 32'h000000AB, 32'h0};
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: drive(0, 1, 1, 0, 0, 32'h102, 32'h000000AB, 0, 0);
        1: drive(0, 1, 0, 2, 1, 32'h100, 0, 1, 32'h100);
        2: drive(0, 1, 0, 0, 0, 32'h102, 0, 0, 0);
        3: drive(0, 1, 0, 0, 1, 32'h102, 0, 0, 0);
        4: drive(0, 1, 1, 1, 0, 32'h100, 32'h00008001, 0, 0);
        5: drive(0, 1, 0, 1, 0, 32'h100, 0, 0, 0);
        default: drive(0, 1, 0, 1, 1, 32'h102, 0, 0, 0);
      endcase
      if (i < 5) begin
        nc++; if (rd0 !== want[i]) begin nf++; $display("FAIL sub_const%0d got %h exp %h", i, rd0, want[i]); end
      end
      nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL sub_model%0d got %h exp %h", i, {o0, o1}, {e0, e1}); end
    end
    nc++; if (rd0 !== 32'h0000AB44) begin nf++; $display("FAIL sub_lhu got %h exp 0000ab44", rd0); end
    nc++; if (rd1 !== 32'hFFFF8001) begin nf++; $display("FAIL sub_lh_pipe got %h exp ffff8001", rd1); end
  endtask

  task automatic test_misalign;
    drive(0, 1, 1, 2, 0, 32'h101, 32'h99999999, 0, 0);
    nc++; if ({v0, er0, rd0} !== {2'b11, 32'h0}) begin nf++; $display("FAIL mis_sw got %h exp 3_00000000", {v0, er0, rd0}); end
    drive(0, 1, 0, 1, 0, 32'h103, 0, 1, 32'h102);
    nc++; if ({er0, ie0, in0} !== {2'b11, 32'h0}) begin nf++; $display("FAIL mis_lh_fetch got %h exp 3_00000000", {er0, ie0, in0}); end
    nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL mis_model1 got %h exp %h", {o0, o1}, {e0, e1}); end
    drive(0, 1, 0, 3, 0, 32'h100, 0, 0, 0);
    nc++; if ({v0, er0, rd0} !== {2'b11, 32'h0}) begin nf++; $display("FAIL mis_size3 got %h exp 3_00000000", {v0, er0, rd0}); end
    drive(0, 1, 0, 2, 0, 32'h100, 0, 0, 0);
    nc++; if ({er0, rd0} !== {1'b0, 32'h8001AB44}) begin nf++; $display("FAIL mis_unchanged got %h exp 0_8001ab44", {er0, rd0}); end
    nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL mis_model2 got %h exp %h", {o0, o1}, {e0, e1}); end
  endtask

  task automatic test_collision;
    drive(0, 1, 1, 2, 0, 32'h200, 32'hDEADBEEF, 0, 0);
    drive(0, 1, 1, 2, 0, 32'h200, 32'hCAFEF00D, 1, 32'h200);
    nc++; if (in0 !== 32'hDEADBEEF) begin nf++; $display("FAIL col_old got %h exp deadbeef", in0); end
    nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL col_model got %h exp %h", {o0, o1}, {e0, e1}); end
    drive(0, 1, 0, 2, 0, 32'h200, 0, 1, 32'h200);
    nc++; if ({rd0, in0, in1} !== {32'hCAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF}) begin nf++; $display("FAIL col_new got %h exp cafef00d_cafef00d_deadbeef", {rd0, in0, in1}); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] seq [4] = '{32'h100, 32'h104, 32'h200, 32'h100};
    logic [31:0] want [4] = '{32'h8001AB44, 32'h0A0B0C0D, 32'hCAFEF00D, 32'h8001AB44};
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(0, 1, 0, 2, 0, seq[i], 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL b2b_model%0d got %h exp %h", i, {o0, o1}, {e0, e1}); end
      if (i == 0 || i == 5) begin
        nc++; if (v1 !== 1'b0) begin nf++; $display("FAIL b2b_edge%0d got %b exp 0", i, v1); end
      end else begin
        nc++; if ({v1, rd1} !== {1'b1, want[i-1]}) begin nf++; $display("FAIL b2b_resp%0d got %h exp 1_%h", i, {v1, rd1}, want[i-1]); end
      end
    end
  endtask

  task automatic test_reset_inflight;
    drive(0, 1, 0, 2, 0, 32'h100, 0, 1, 32'h100);
    drive(0, 1, 0, 2, 0, 32'h104, 0, 1, 32'h104);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      nc++; if ({o0, o1} !== '0) begin nf++; $display("FAIL rst_flight%0d got %h exp 0", i, {o0, o1}); end
    end
  endtask

  task automatic test_wrap;
    drive(0, 1, 1, 2, 0, 32'h00001004, 32'h13572468, 0, 0);
    drive(0, 1, 0, 2, 0, 32'h00000004, 0, 1, 32'hFFFFF004);
    nc++; if ({rd0, in0} !== {32'h13572468, 32'h13572468}) begin nf++; $display("FAIL wrap got %h exp 13572468_13572468", {rd0, in0}); end
    nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL wrap_model got %h exp %h", {o0, o1}, {e0, e1}); end
  endtask

  task automatic test_random;
    logic [31:0] hi, a, pc;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 1, 2, 0, 32'h300 + 32'(4 * i), $urandom, 0, 0);
      nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL rnd_init%0d got %h exp %h", i, {o0, o1}, {e0, e1}); end
    end
    for (int i = 0; i < 400; i++) begin
      hi = $urandom;
      a = {hi[31:12], 12'h300 + 12'($urandom_range(0, 63))};
      hi = $urandom;
      pc = {hi[31:12], 12'h300 + 12'($urandom_range(0, 63))};
      drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), pc);
      nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL rnd%0d got %h exp %h", i, {o0, o1}, {e0, e1}); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      nc++; if ({o0, o1} !== {e0, e1}) begin nf++; $display("FAIL rnd_drain%0d got %h exp %h", i, {o0, o1}, {e0, e1}); end
    end
  endtask

  initial begin
    test_reset();
    test_word_roundtrip();
    test_subword();
    test_misalign();
    test_collision();
    test_back_to_back();
    test_reset_inflight();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
